// File: rtl/en_serial_cmp_ctrl_pkg.sv
// Shared definitions for the lsi_10k serial controllers.
// The state encodings are fixed so that later serial controllers decode them the same way.
package en_serial_cmp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/en_serial_cmp_ctrl_if.sv
// Handshake and operand/result bundle for the serial word comparator.
interface en_serial_cmp_ctrl_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          START;
    logic          ABORT;
    logic [W-1:0]  A_IN;
    logic [W-1:0]  B_IN;
    logic          BUSY;
    logic          DONE;
    logic          EQ;
    logic [CW-1:0] MCNT;

    modport master (output START, ABORT, A_IN, B_IN, input BUSY, DONE, EQ, MCNT);
    modport slave  (input START, ABORT, A_IN, B_IN, output BUSY, DONE, EQ, MCNT);
endinterface

// File: rtl/en_serial_cmp_ctrl_en.sv
// lsi_10k EN cell: 2-input XNOR, Z = ~(A ^ B).
module en_serial_cmp_ctrl_en (
    input  logic A,
    input  logic B,
    output logic Z
);
    assign Z = ~(A ^ B);
endmodule

// File: rtl/en_serial_cmp_ctrl.sv
// Bit-serial word comparator: one EN cell time-shared over W bit pairs,
// counting matching positions and reporting EQ/MCNT with a START/BUSY/DONE handshake.
module en_serial_cmp_ctrl
    import en_serial_cmp_ctrl_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input logic                 CP,
    input logic                 CD,
    en_serial_cmp_ctrl_if.slave bus
);

    state_e        st_q, st_d;
    logic [W-1:0]  sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0] acc_q, acc_d, bitcnt_q, bitcnt_d, mcnt_q, mcnt_d;
    logic          busy_q, busy_d, done_q, done_d, eq_q, eq_d;
    logic          match, last;
    logic [CW-1:0] acc_sum;

    en_serial_cmp_ctrl_en u_en (
        .A (sa_q[0]),
        .B (sb_q[0]),
        .Z (match)
    );

    assign last    = (bitcnt_q == CW'(W - 1));
    assign acc_sum = acc_q + CW'(match);

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) st_q <= ST_IDLE;
        else     st_q <= st_d;
    end

    // ABORT outranks the final SHIFT edge, so an aborted compare never reports.
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:  if (bus.START) st_d = ST_SHIFT;
            ST_SHIFT: begin
                if (bus.ABORT)  st_d = ST_IDLE;
                else if (last)  st_d = ST_DONE;
            end
            ST_DONE:  st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        bitcnt_d = bitcnt_q;
        mcnt_d   = mcnt_q;
        eq_d     = eq_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (bus.START) begin
                    sa_d     = bus.A_IN;
                    sb_d     = bus.B_IN;
                    acc_d    = '0;
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.ABORT) begin
                    busy_d = 1'b0;
                end else begin
                    sa_d     = sa_q >> 1;
                    sb_d     = sb_q >> 1;
                    acc_d    = acc_sum;
                    bitcnt_d = bitcnt_q + 1'b1;
                    // EQ comes from the final count, not a running AND.
                    if (last) begin
                        mcnt_d = acc_sum;
                        eq_d   = (acc_sum == CW'(W));
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            bitcnt_q <= '0;
            mcnt_q   <= '0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            mcnt_q   <= mcnt_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.EQ   = eq_q;
    assign bus.MCNT = mcnt_q;

endmodule

// File: tb/tb_en_serial_cmp_ctrl.sv
// Directed bench for en_serial_cmp_ctrl: W=8 and W=1 instances sharing clock and reset.
module tb_en_serial_cmp_ctrl;

    logic CP = 1'b0;
    logic CD = 1'b1;
    always #5 CP = ~CP;

    en_serial_cmp_ctrl_if #(.W(8), .CW(4)) bus8 ();
    en_serial_cmp_ctrl_if #(.W(1), .CW(1)) bus1 ();

    en_serial_cmp_ctrl #(.W(8), .CW(4)) dut8 (.CP(CP), .CD(CD), .bus(bus8));
    en_serial_cmp_ctrl #(.W(1), .CW(1)) dut1 (.CP(CP), .CD(CD), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    // Accept a compare at the next edge, then scramble the operand inputs.
    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        bus8.START = 1'b1;
        bus8.A_IN  = a;
        bus8.B_IN  = b;
        tick();
        bus8.START = 1'b0;
        bus8.A_IN  = ~a;
        bus8.B_IN  = b;
        chk("accept_busy", {31'd0, bus8.BUSY}, 32'd1);
    endtask

    task automatic finish8(input string tag, input int exp_m, input logic exp_eq);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus8.DONE && n < 20);
        chk({tag, "_latency"}, n, 32'd8);
        chk({tag, "_mcnt"}, {28'd0, bus8.MCNT}, exp_m);
        chk({tag, "_eq"}, {31'd0, bus8.EQ}, {31'd0, exp_eq});
        chk({tag, "_busy_low"}, {31'd0, bus8.BUSY}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, bus8.DONE}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a, b;
        bus8.START = 0; bus8.ABORT = 0; bus8.A_IN = '0; bus8.B_IN = '0;
        bus1.START = 0; bus1.ABORT = 0; bus1.A_IN = '0; bus1.B_IN = '0;

        #1 CD = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bus8.BUSY}, 32'd0);
        chk("rst_done", {31'd0, bus8.DONE}, 32'd0);
        chk("rst_eq",   {31'd0, bus8.EQ},   32'd0);
        chk("rst_mcnt", {28'd0, bus8.MCNT}, 32'd0);
        chk("rst_w1_mcnt", {31'd0, bus1.MCNT}, 32'd0);
        repeat (2) @(posedge CP);
        #1 CD = 1'b1;
        tick();

        // Equal words, then all-mismatch and partial match.
        start8(8'hA5, 8'hA5); finish8("t1", 8, 1'b1);
        tick();
        chk("t1_hold_mcnt", {28'd0, bus8.MCNT}, 32'd8);
        chk("t1_hold_eq",   {31'd0, bus8.EQ},   32'd1);
        start8(8'hFF, 8'h00); finish8("t2a", 0, 1'b0);
        start8(8'hF0, 8'hF3); finish8("t2b", 6, 1'b0);

        // START held high: accepts at cycles 0 and 10 only; other operands are decoys.
        bus8.START = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 0)       begin a = 8'hA5; b = 8'h5A; end
            else if (c == 10) begin a = 8'hF0; b = 8'hF3; end
            else              begin a = 8'hFF; b = 8'hFF; end
            bus8.A_IN = a;
            bus8.B_IN = b;
            tick();
            chk($sformatf("t3_busy_c%0d", c), {31'd0, bus8.BUSY}, {31'd0, (c % 10) < 8});
            chk($sformatf("t3_done_c%0d", c), {31'd0, bus8.DONE}, {31'd0, (c % 10) == 8});
            if (c == 8)  chk("t3_mcnt_first",  {28'd0, bus8.MCNT}, 32'd0);
            if (c == 18) chk("t3_mcnt_second", {28'd0, bus8.MCNT}, 32'd6);
        end
        bus8.START = 1'b0;
        tick();

        // Abort mid-compare keeps the previous result; START with ABORT in IDLE is accepted.
        start8(8'hA5, 8'hA5); finish8("t4a", 8, 1'b1);
        start8(8'h0F, 8'h00);
        tick(); tick();
        bus8.ABORT = 1'b1;
        tick();
        chk("t4_abort_busy", {31'd0, bus8.BUSY}, 32'd0);
        chk("t4_abort_done", {31'd0, bus8.DONE}, 32'd0);
        chk("t4_abort_eq",   {31'd0, bus8.EQ},   32'd1);
        chk("t4_abort_mcnt", {28'd0, bus8.MCNT}, 32'd8);
        bus8.START = 1'b1; bus8.A_IN = 8'h0F; bus8.B_IN = 8'h00;
        tick();
        bus8.START = 1'b0; bus8.ABORT = 1'b0; bus8.A_IN = 8'hAA;
        chk("t4_restart_busy", {31'd0, bus8.BUSY}, 32'd1);
        finish8("t4b", 4, 1'b0);

        // ABORT on the final SHIFT edge suppresses the result.
        start8(8'hFF, 8'hFF);
        repeat (7) tick();
        bus8.ABORT = 1'b1;
        tick();
        bus8.ABORT = 1'b0;
        chk("t4_lastabort_done", {31'd0, bus8.DONE}, 32'd0);
        chk("t4_lastabort_busy", {31'd0, bus8.BUSY}, 32'd0);
        chk("t4_lastabort_mcnt", {28'd0, bus8.MCNT}, 32'd4);
        tick();
        chk("t4_lastabort_late", {31'd0, bus8.DONE}, 32'd0);

        // Asynchronous reset in the middle of a compare.
        start8(8'hAA, 8'h55);
        repeat (3) tick();
        @(posedge CP);
        #1 CD = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, bus8.BUSY}, 32'd0);
        chk("t5_rst_done", {31'd0, bus8.DONE}, 32'd0);
        chk("t5_rst_eq",   {31'd0, bus8.EQ},   32'd0);
        chk("t5_rst_mcnt", {28'd0, bus8.MCNT}, 32'd0);
        #3 CD = 1'b1;
        tick();
        start8(8'h3C, 8'h3C); finish8("t5", 8, 1'b1);

        // Single-bit instance.
        bus1.START = 1'b1; bus1.A_IN = 1'b1; bus1.B_IN = 1'b0;
        tick();
        bus1.START = 1'b0; bus1.A_IN = 1'b0; bus1.B_IN = 1'b0;
        chk("t6a_busy", {31'd0, bus1.BUSY}, 32'd1);
        tick();
        chk("t6a_done", {31'd0, bus1.DONE}, 32'd1);
        chk("t6a_busy_low", {31'd0, bus1.BUSY}, 32'd0);
        chk("t6a_mcnt", {31'd0, bus1.MCNT}, 32'd0);
        chk("t6a_eq",   {31'd0, bus1.EQ},   32'd0);
        tick();
        chk("t6a_done_pulse", {31'd0, bus1.DONE}, 32'd0);
        bus1.START = 1'b1; bus1.A_IN = 1'b1; bus1.B_IN = 1'b1;
        tick();
        bus1.START = 1'b0; bus1.B_IN = 1'b0;
        tick();
        chk("t6b_done", {31'd0, bus1.DONE}, 32'd1);
        chk("t6b_mcnt", {31'd0, bus1.MCNT}, 32'd1);
        chk("t6b_eq",   {31'd0, bus1.EQ},   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/en_serial_cmp_ctrl.md
Name: en_serial_cmp_ctrl

Overview:
Bit-serial word comparator controller built around one lsi_10k EN (2-input XNOR) cell. On START it loads two W-bit operands and drives one bit pair per clock through the EN cell. It counts matching bit positions and reports EQ (all bits match) and MCNT (match count) with a START/BUSY/DONE handshake. It is the sequencer that time-shares a single XNOR cell across a whole word, for area-critical compare paths in lsi_10k netlists.

Parameters:
W, 8, operand width in bits; legal range 1..32
CW, 4, MCNT width; must be at least clog2(W+1) (4 for W=8)

Ports:
CP  input  1  clock; rising-edge active
CD  input  1  asynchronous active-low reset (clear direct)
START  input  1  request compare; sampled only in IDLE
ABORT  input  1  synchronous cancel of an in-progress compare
A_IN  input  W  operand A; sampled on the accepting edge only
B_IN  input  W  operand B; sampled on the accepting edge only
BUSY  output  1  compare in progress
DONE  output  1  one-cycle result-valid pulse
EQ  output  1  1 when all W bit pairs matched
MCNT  output  CW  number of matching bit positions, 0..W

Behaviour:
- Reset: CD low immediately forces the following, independent of CP:
  - state=IDLE, BUSY=0, DONE=0, EQ=0, MCNT=0
  - SA=0, SB=0, BITCNT=0, ACC=0
  - Reset released mid-compare: no result is produced and the block restarts in IDLE.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - START=1 at a CP edge (edge 0): SA<=A_IN, SB<=B_IN, ACC<=0, BITCNT<=0, BUSY<=1, state<=SHIFT.
  - START=0: stay in IDLE; EQ and MCNT hold their last result.
- SHIFT, at each edge n=1..W:
  - EN cell inputs are SA[0] and SB[0]. If the cell output is 1, ACC<=ACC+1.
  - SA and SB shift right with zero fill; BITCNT<=BITCNT+1.
  - On the edge where BITCNT==W-1 (edge W): MCNT<=ACC+match, EQ<=(ACC+match==W), DONE<=1, BUSY<=0, state<=DONE.
- DONE: at the next edge (W+1), DONE<=0 and state<=IDLE. START asserted during the DONE state is ignored; the earliest acceptance is edge W+2.
- Latency: START accepted at edge 0, DONE high between edge W and edge W+1. BUSY is high for exactly W cycles. Throughput is one compare per W+2 cycles.
- START while BUSY or in DONE: ignored, with no effect on operands or result.
- ABORT=1 in SHIFT: state<=IDLE, BUSY<=0. No DONE pulse; EQ and MCNT keep the previous result. ABORT in IDLE or DONE has no effect.
- ABORT and START both high in IDLE: START is accepted.
- ABORT on the final SHIFT edge: ABORT wins and no result is produced.
- Arithmetic:
  - ACC is CW bits and saturation is impossible because W<=2^CW-1.
  - EQ is derived from the final count, not from a running AND, so EQ=1 iff MCNT==W.
- Timing: the EN worst-case path (2.46 ns fall) plus the ACC increment and setup must fit the CP period. Target CP period >= 10 ns at the worst corner.
- W=1: a single SHIFT cycle; DONE at edge 1.

Decomposition:
- Shared include lsi_ctrl_defs holds the state encodings ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10, reused by later serial controllers.
- One sub-module: the EN cell instance (A=SA[0], B=SB[0], Z=match). It is instantiated directly so the netlist keeps the cell's specify timing.
- No further hierarchy.

Test Plan:
1. W=8, A_IN=8'hA5, B_IN=8'hA5, START pulse -> BUSY for 8 cycles; DONE pulse after edge 8; EQ=1, MCNT=8.
2. A_IN=8'hFF, B_IN=8'h00 -> DONE after edge 8; EQ=0, MCNT=0. Then A_IN=8'hF0, B_IN=8'hF3 -> EQ=0, MCNT=6.
3. START held continuously with varied operands -> operands sampled only at the accepting edge; START ignored in SHIFT and DONE; successive DONE pulses exactly 10 cycles apart.
4. Run test 1, then start 8'h0F vs 8'h00 and assert ABORT at edge 3 -> BUSY falls and no DONE pulse; EQ=1, MCNT=8 retained; a new START is accepted at the next edge.
5. CD driven low asynchronously at edge 4 of a compare -> BUSY, DONE, EQ and MCNT are 0 before the next CP edge. After CD release, a 8'h3C vs 8'h3C compare gives EQ=1, MCNT=8.
6. Rebuild with W=1, CW=1; 1'b1 vs 1'b0 -> DONE after edge 1, MCNT=0, EQ=0. 1'b1 vs 1'b1 -> MCNT=1, EQ=1.
